// File: rtl/controlador_interrupcao_if.sv
// rtl/controlador_interrupcao_if.sv - control-unit/PC-path bus of the interrupt controller
// master = control unit and PC path, slave = controller.
interface controlador_interrupcao_if #(
  parameter int NUM_SOURCES = 4,
  parameter int PC_WIDTH    = 11,
  parameter int TIME_WIDTH  = 16
);
  logic                   halt;
  logic                   set_clock;
  logic [TIME_WIDTH-1:0]  int_time;
  logic [NUM_SOURCES-1:0] irq_ext;
  logic [NUM_SOURCES-1:0] mask;
  logic [PC_WIDTH-1:0]    pc;
  logic                   get_interruption;
  logic                   reti;
  logic                   int_taken;
  logic [PC_WIDTH-1:0]    saved_pc;
  logic [PC_WIDTH-1:0]    pc_next;
  logic [31:0]            cause;
  logic                   in_service;
  logic [TIME_WIDTH-1:0]  timer_count;

  modport master (
    output halt, set_clock, int_time, irq_ext, mask, pc, get_interruption, reti,
    input  int_taken, saved_pc, pc_next, cause, in_service, timer_count
  );

  modport slave (
    input  halt, set_clock, int_time, irq_ext, mask, pc, get_interruption, reti,
    output int_taken, saved_pc, pc_next, cause, in_service, timer_count
  );
endinterface

// File: rtl/controlador_interrupcao.sv
// rtl/controlador_interrupcao.sv - fixed-priority halt/timer/external interrupt controller
// Halt > quantum timer > external lines (lowest index first); one handler at a time until reti.
module controlador_interrupcao #(
  parameter int                  NUM_SOURCES = 4,
  parameter int                  PC_WIDTH    = 11,
  parameter int                  TIME_WIDTH  = 16,
  parameter bit                  AUTO_RELOAD = 1'b1,
  parameter logic [PC_WIDTH-1:0] VECTOR      = '0
) (
  input logic                   clk,
  input logic                   rst_n,
  controlador_interrupcao_if.slave bus
);

  logic [NUM_SOURCES-1:0] irq_prev;
  logic [NUM_SOURCES-1:0] ext_pending;
  logic [NUM_SOURCES-1:0] ext_rise;
  logic [NUM_SOURCES-1:0] ext_req;
  logic [NUM_SOURCES-1:0] ext_win;
  logic [31:0]            ext_code;
  logic [TIME_WIDTH-1:0]  reload;
  logic [TIME_WIDTH-1:0]  timer_count_q;
  logic                   run;
  logic                   timer_pending;
  logic                   int_taken_q;
  logic [PC_WIDTH-1:0]    saved_pc_q;
  logic [31:0]            cause_q;
  logic                   in_service_q;
  logic                   accept;
  logic                   take_timer;
  logic                   take_ext;
  logic                   timer_expire;

  assign ext_rise = bus.irq_ext & ~irq_prev;
  assign ext_req  = ext_pending & bus.mask;

  // Walk from the top so the lowest enabled index is the one left standing.
  always_comb begin
    ext_win  = '0;
    ext_code = 32'd0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (ext_req[i]) begin
        ext_win    = '0;
        ext_win[i] = 1'b1;
        ext_code   = 32'd3 + 32'(i);
      end
    end
  end

  assign accept       = !in_service_q && (timer_pending || (|ext_req));
  assign take_timer   = accept && timer_pending;
  assign take_ext     = accept && !timer_pending;
  assign timer_expire = run && !in_service_q && !bus.set_clock
                        && (timer_count_q == TIME_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev      <= '0;
      ext_pending   <= '0;
      reload        <= '0;
      timer_count_q <= '0;
      run           <= 1'b0;
      timer_pending <= 1'b0;
      int_taken_q   <= 1'b0;
      saved_pc_q    <= '0;
      cause_q       <= 32'd0;
      in_service_q  <= 1'b0;
    end else begin
      irq_prev    <= bus.irq_ext;
      int_taken_q <= 1'b0;
      if (bus.halt) begin
        int_taken_q   <= 1'b1;
        cause_q       <= 32'd2;
        in_service_q  <= 1'b1;
        ext_pending   <= '0;
        timer_pending <= 1'b0;
        run           <= 1'b0;
        timer_count_q <= '0;
      end else begin
        ext_pending   <= (ext_pending & ~(ext_win & {NUM_SOURCES{take_ext}})) | ext_rise;
        timer_pending <= (timer_pending & ~take_timer) | timer_expire;

        if (bus.set_clock) begin
          reload        <= bus.int_time;
          timer_count_q <= bus.int_time;
          run           <= |bus.int_time;
        end else if (run && !in_service_q) begin
          // A running count of zero only exists for one cycle after expiry in reload mode.
          if (timer_count_q == '0) begin
            timer_count_q <= reload;
          end else begin
            timer_count_q <= timer_count_q - TIME_WIDTH'(1);
            if (timer_expire && !AUTO_RELOAD) run <= 1'b0;
          end
        end

        if (bus.get_interruption) cause_q <= 32'd0;
        if (bus.reti) in_service_q <= 1'b0;

        if (accept) begin
          int_taken_q  <= 1'b1;
          saved_pc_q   <= bus.pc;
          cause_q      <= take_timer ? 32'd1 : ext_code;
          in_service_q <= 1'b1;
        end
      end
    end
  end

  assign bus.int_taken   = int_taken_q;
  assign bus.saved_pc    = saved_pc_q;
  assign bus.cause       = cause_q;
  assign bus.in_service  = in_service_q;
  assign bus.timer_count = timer_count_q;
  assign bus.pc_next     = int_taken_q ? VECTOR : bus.pc;

endmodule

// File: doc/controlador_interrupcao.md
Name: controlador_interrupcao

Overview:
- Parametrised successor to the single-timer/halt interrupt logic feeding the PC path of the MIPS CPU.
- Arbitrates halt, a reloadable quantum timer, and NUM_SOURCES maskable external lines by fixed priority.
- On acceptance it captures the return PC, publishes a cause code, raises a one-cycle IntTaken so the PC loads VECTOR, and blocks further acceptance until Reti.
- Sits between the control unit (Halt, SetClock, GetInterruption, Reti) and the PC / PC-buffer / register-write mux.

Parameters:
- NUM_SOURCES, 4: external interrupt lines, 1..8.
- PC_WIDTH, 11: instruction-address width.
- TIME_WIDTH, 16: timer width; IntTime comes from the instruction immediate.
- AUTO_RELOAD, 1: 1 = timer reloads after expiry; 0 = one-shot.
- VECTOR, 0: PC value forced when IntTaken is high (PC_WIDTH bits).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Halt  in  1  halt instruction decoded.
- SetClock  in  1  load timer from IntTime.
- IntTime  in  TIME_WIDTH  timer load value; 0 disables timer.
- IrqExt  in  NUM_SOURCES  external requests, level inputs, rising-edge sensitive.
- Mask  in  NUM_SOURCES  1 = source enabled.
- Pc  in  PC_WIDTH  next-PC value the CPU would load this cycle.
- GetInterruption  in  1  handler read of cause; clears Cause.
- Reti  in  1  return from handler.
- IntTaken  out  1  registered pulse; PC mux selects VECTOR.
- SavedPc  out  PC_WIDTH  captured return address.
- Cause  out  32  0 none, 1 timer, 2 halt, 3+i external i.
- InService  out  1  handler active.
- TimerCount  out  TIME_WIDTH  current countdown.

Behaviour:
- Reset low, asynchronous: all outputs 0; pending bits, reload register and timer-run flag 0; previous-IrqExt register 0.
- External pending: bit i sets on an IrqExt[i] 0->1 edge, registered against the previous sample. Bits are latched regardless of Mask or InService and held until taken. A masked pending bit stays pending and is taken once unmasked.
- Timer, SetClock high:
  - Next edge: reload = IntTime, TimerCount = IntTime, run = (IntTime != 0).
  - SetClock overrides a simultaneous expiry; that expiry is lost.
- Timer, running:
  - Decrements by 1 per cycle while run=1 and InService=0; frozen while InService=1.
  - At the edge where TimerCount goes 1->0, timer_pending sets.
  - AUTO_RELOAD=1: TimerCount = reload on the following edge, run stays 1.
  - AUTO_RELOAD=0: run clears.
- Priority: Halt > timer_pending > external, lowest index first.
- Acceptance when InService=0 and a non-halt candidate exists (timer_pending, or pending & Mask nonzero). Next edge:
  - IntTaken=1 for exactly one cycle.
  - SavedPc = Pc.
  - Cause = winner code.
  - InService = 1.
  - Winner's pending bit cleared; other pendings retained.
- Halt:
  - Taken regardless of InService.
  - Next edge: IntTaken=1, Cause=2, InService=1; all pending bits cleared; run=0, TimerCount=0.
  - SavedPc is not updated.
  - Halt beats a simultaneous Reti, GetInterruption or other source.
- Latency: request visible at the pin to IntTaken = 1 cycle for Halt/timer_pending, 2 cycles for IrqExt (edge register + arbitration).
- GetInterruption: Cause = 0 next edge; SavedPc and InService unchanged.
- Reti: InService = 0 next edge. No acceptance occurs in the Reti cycle; the earliest new IntTaken is on the edge after InService falls.
- Reti with InService=0: ignored. GetInterruption with Cause=0: no effect.
- Reset asserted mid-handler: immediate return to the reset state; no IntTaken pulse on release.

Test Plan:
- Reset low, then high; IrqExt=0 -> all outputs 0 for 10 cycles; TimerCount=0.
- SetClock with IntTime=5, Pc=0x123 -> TimerCount 5,4,3,2,1,0. IntTaken pulses one cycle after reaching 0, with Cause=1, SavedPc=0x123, InService=1. TimerCount reloads 5 and stays frozen until Reti.
- IrqExt=4'b0110, Mask=4'b1111 -> first take Cause=4 (source 1). After GetInterruption and Reti, the next take is Cause=5 (source 2) with no new edge required.
- Mask=0 and an IrqExt[0] edge -> no IntTaken. Set Mask[0]=1 -> IntTaken on the next edge with Cause=3.
- During InService, Halt=1 plus an IrqExt edge -> IntTaken, Cause=2, SavedPc unchanged, all pending cleared, TimerCount=0.
- Timer expiry coincides with SetClock (IntTime=9), and Reti coincides with a pending external -> no timer take and TimerCount=9. The external is taken exactly one cycle after InService falls.
